// File: rtl/wb_debug_master.sv
// wb_debug_master
//   Wishbone classic single-transfer initiator for debug/bring-up access to
//   slave registers. It takes one command at a time, runs one Wishbone cycle
//   for it, and returns read data and error status on a response port.
//   A cycle that gets no ack within TIMEOUT_CYCLES is aborted with rsp_err=1.
//
// Ports
//   wb_clk_i, wb_rst_i      clock; asynchronous active-high reset
//   req_valid/req_ready     command handshake (req_ready = block is IDLE)
//   req_we/adr/dat/sel      command: direction, byte address, write data,
//                           byte enables
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat, rsp_err        read data (0 for writes and aborts), timeout flag
//   wbm_*                   Wishbone classic master interface
//
// Parameters
//   TIMEOUT_CYCLES  longest time cyc/stb stay high awaiting ack (2..65535)
//   TO_W            timeout counter width, 2**TO_W > TIMEOUT_CYCLES

module wb_debug_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  // The asynchronous reset drops cyc/stb immediately and discards any
  // pending response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      wdat_q      <= 32'h0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: every signal written here gets a hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cyc_d   = 1'b1;
          we_d    = req_we;
          sel_d   = req_sel;
          adr_d   = req_adr;
          // Reads put zero on the write-data lines rather than stale data.
          wdat_d  = req_we ? req_dat : 32'h0;
          cnt_d   = '0;
          state_d = BUS;
        end
      end

      BUS: begin
        if (wbm_ack_i || (cnt_q == CNT_LAST)) begin
          // An ack on the timeout edge still wins: completion, not abort.
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'h0;
          adr_d       = 32'h0;
          wdat_d      = 32'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~wbm_ack_i;
          rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_debug_master.sv
// tb_wb_debug_master
//   Directed bench for wb_debug_master (TIMEOUT_CYCLES=16). A small
//   registered-ack slave with 16 word registers answers bus cycles when
//   slave_en is set; force_ack/force_dat inject acks by hand for the
//   timeout, collision and late-ack cases.

module tb_wb_debug_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_debug_master #(.TIMEOUT_CYCLES(16), .TO_W(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  // Slave model: ack one cycle after it sees cyc&stb (registered ack).
  logic        slave_en = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] s_dat = 32'h0;
  logic [31:0] mem [0:15];
  logic        force_ack = 1'b0;
  logic [31:0] force_dat = 32'h0;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

  always @(posedge wb_clk_i) begin
    if (slave_en && wbm_cyc_o && wbm_stb_o && !ack_r) begin
      ack_r <= 1'b1;
      if (wbm_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b]) mem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end else begin
        s_dat <= mem[wbm_adr_o[5:2]];
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  assign wbm_ack_i = ack_r | force_ack;
  assign wbm_dat_i = force_ack ? force_dat : s_dat;

  // Counts clock edges at which cyc was high (pre-edge value).
  int cyc_cnt = 0;
  always @(posedge wb_clk_i) if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one command, let it be accepted, check the bus it drives.
  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    req_valid = 1'b1;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    cyc_cnt = 0;
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    check("cyc_up", {31'b0, wbm_cyc_o}, 32'd1);
    check("stb_up", {31'b0, wbm_stb_o}, 32'd1);
    check("we_o", {31'b0, wbm_we_o}, {31'b0, we});
    check("adr_o", wbm_adr_o, adr);
    check("sel_o", {28'b0, wbm_sel_o}, {28'b0, sel});
    check("req_ready_bus", {31'b0, req_ready}, 32'd0);
  endtask

  // Wait (bounded) for rsp_valid; while cyc is high the write data must hold.
  task automatic wait_rsp(input logic [31:0] exp_wdat, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      if (wbm_cyc_o) check("wdat_hold", wbm_dat_o, exp_wdat);
      @(negedge wb_clk_i);
      lat++;
    end
    check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    check("bus_idle_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("bus_idle_adr", wbm_adr_o, 32'h0);
    check("bus_idle_dat", wbm_dat_o, 32'h0);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("rsp_dat_clr", rsp_dat, 32'h0);
    check("rsp_err_clr", {31'b0, rsp_err}, 32'd0);
    check("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  int lat;
  logic [31:0] held;

  initial begin
    wb_rst_i = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = 32'h0; req_dat = 32'h0;
    req_sel = 4'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Reset state
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'b0, wbm_we_o}, 32'd0);
    check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_dat_o", wbm_dat_o, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Full-word write, slave acks the cycle after stb
    slave_en = 1'b1;
    issue(1'b1, 32'h3000_0008, 32'hA5A5_1234, 4'hF);
    wait_rsp(32'hA5A5_1234, lat);
    check("wr_latency", lat, 32'd2);
    check("wr_cyc_cycles", cyc_cnt, 32'd2);
    check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    consume();

    // Read back
    issue(1'b0, 32'h3000_0008, 32'hFFFF_FFFF, 4'hF);
    wait_rsp(32'h0, lat);
    check("rd1_dat", rsp_dat, 32'hA5A5_1234);
    check("rd1_err", {31'b0, rsp_err}, 32'd0);
    consume();

    // Byte-1 write then read back
    issue(1'b1, 32'h3000_0008, 32'h0000_FF00, 4'b0010);
    wait_rsp(32'h0000_FF00, lat);
    consume();
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(32'h0, lat);
    check("rd2_dat", rsp_dat, 32'hA5A5_FF34);
    consume();

    // Timeout: no ack, cyc high exactly 16 cycles
    slave_en = 1'b0;
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    wait_rsp(32'h0, lat);
    check("to_cyc_cycles", cyc_cnt, 32'd16);
    check("to_err", {31'b0, rsp_err}, 32'd1);
    check("to_dat", rsp_dat, 32'h0);
    // Late ack three cycles later must not disturb the held response
    repeat (2) @(negedge wb_clk_i);
    force_dat = 32'h1234_5678; force_ack = 1'b1;
    @(negedge wb_clk_i);
    force_ack = 1'b0;
    check("late_valid", {31'b0, rsp_valid}, 32'd1);
    check("late_err", {31'b0, rsp_err}, 32'd1);
    check("late_dat", rsp_dat, 32'h0);
    check("late_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    consume();

    // Ack on the 16th BUS cycle beats the timeout
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    repeat (15) @(negedge wb_clk_i);
    force_dat = 32'hDEAD_BEEF; force_ack = 1'b1;
    @(negedge wb_clk_i);
    force_ack = 1'b0;
    check("col_valid", {31'b0, rsp_valid}, 32'd1);
    check("col_err", {31'b0, rsp_err}, 32'd0);
    check("col_dat", rsp_dat, 32'hDEAD_BEEF);
    check("col_cyc_cycles", cyc_cnt, 32'd16);
    consume();

    // Backpressure: response held while a new command waits
    slave_en = 1'b1;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(32'h0, lat);
    held = rsp_dat;
    check("bp_first_dat", held, 32'hA5A5_FF34);
    req_we = 1'b0; req_adr = 32'h3000_0008; req_sel = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_dat", rsp_dat, 32'hA5A5_FF34);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_no_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    check("bp_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("bp_ready_up", {31'b0, req_ready}, 32'd1);
    check("bp_gap_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    check("bp_next_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    wait_rsp(32'h0, lat);
    check("bp_next_dat", rsp_dat, 32'hA5A5_FF34);
    consume();

    // Reset one cycle after cyc rises
    slave_en = 1'b0;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    check("arst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("arst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("arst_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    slave_en = 1'b1;
    @(negedge wb_clk_i);
    check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(32'h0, lat);
    check("post_rst_dat", rsp_dat, 32'hA5A5_FF34);
    check("post_rst_err", {31'b0, rsp_err}, 32'd0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
